// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch path: word/address widths,
// opcode field placement, the fetch FSM state type and an opcode helper.
// The control unit imports this package so both agree on opcode position.
package fetch_pkg;

  // Architectural widths of the 60-bit processor.
  localparam int INSTR_W  = 60;
  localparam int ADDR_W   = 16;
  localparam int OPCODE_W = 4;

  // Opcode occupies the top OPCODE_W bits of the instruction word.
  localparam int OPCODE_MSB = INSTR_W - 1;
  localparam int OPCODE_LSB = INSTR_W - OPCODE_W;

  // Fetch sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  // Extract the opcode field from an instruction word.
  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB -: OPCODE_W];
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Bundles the instruction-memory request/response channel and the
// fetched-instruction channel toward decode. The master side is the fetch
// sequencer; the slave side is the memory plus decode environment.
interface fetch_sequencer_if;
  import fetch_pkg::*;

  // Instruction-memory request channel (valid/ready).
  logic                imem_req_valid;
  logic                imem_req_ready;
  logic [ADDR_W-1:0]   imem_req_addr;

  // Instruction-memory response: one pulse per accepted request.
  logic                imem_rsp_valid;
  logic [INSTR_W-1:0]  imem_rsp_data;

  // Fetched instruction toward decode (valid/ready).
  logic                instr_valid;
  logic                instr_ready;
  logic [INSTR_W-1:0]  instr_data;
  logic [ADDR_W-1:0]   instr_pc;
  logic [OPCODE_W-1:0] opcode;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    output instr_valid,
    output instr_data,
    output instr_pc,
    output opcode,
    input  instr_ready
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    input  instr_valid,
    input  instr_data,
    input  instr_pc,
    input  opcode,
    output instr_ready
  );

endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, keeps at most one instruction
// memory read outstanding, and hands each fetched word to decode. Jumps and
// taken branches redirect the PC; a fetch already in flight when a redirect
// arrives is marked stale and its response is dropped.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master bus,
  input  logic              branch_en,
  input  logic              jump_en,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] target_addr,
  output logic              fetch_busy
);

  fetch_state_e       state;
  logic [ADDR_W-1:0]  pc;
  logic               discard;
  logic [INSTR_W-1:0] instr_data_q;
  logic [ADDR_W-1:0]  instr_pc_q;
  logic               redirect;

  // A redirect is either an unconditional jump or a taken branch.
  assign redirect = jump_en | (branch_en & branch_taken);

  // FSM, PC and instruction registers updated together on each rising edge.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch below reads the pre-edge values of state/pc/discard regardless
  // of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      discard      <= 1'b0;
      instr_data_q <= '0;
      instr_pc_q   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (redirect) begin
            pc <= target_addr;
          end
          state <= REQ;
        end

        REQ: begin
          // Unaccepted request may retarget freely; an accepted one that is
          // redirected in the same cycle is already stale.
          if (redirect) begin
            pc <= target_addr;
          end
          if (bus.imem_req_ready) begin
            discard <= redirect;
            state   <= WAIT;
          end
        end

        WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (redirect) begin
              // Response in hand is stale; nothing else is outstanding.
              pc      <= target_addr;
              discard <= 1'b0;
              state   <= REQ;
            end else if (discard) begin
              discard <= 1'b0;
              state   <= REQ;
            end else begin
              instr_data_q <= bus.imem_rsp_data;
              instr_pc_q   <= pc;
              state        <= HOLD;
            end
          end else if (redirect) begin
            pc      <= target_addr;
            discard <= 1'b1;
          end
        end

        HOLD: begin
          // The held word is withdrawn on redirect; a simultaneous handshake
          // still completes but the PC follows the target, not pc+1.
          if (redirect) begin
            pc    <= target_addr;
            state <= REQ;
          end else if (bus.instr_ready) begin
            pc    <= pc + 1'b1;
            state <= REQ;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Handshake valids decode straight from the state register, so they have
  // no combinational path from any input.
  assign bus.imem_req_valid = (state == REQ);
  assign bus.instr_valid    = (state == HOLD);
  assign bus.imem_req_addr  = pc;
  assign bus.instr_data     = instr_data_q;
  assign bus.instr_pc       = instr_pc_q;
  assign bus.opcode         = opcode_of(instr_data_q);
  assign fetch_busy         = (state != IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a per-cycle vector table drives the
// memory/decode/redirect inputs and checks every output, a behavioural
// memory answers accepted requests after a programmable latency, and
// hand-written sequences cover reset-in-WAIT and PC wrap (second instance).
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_sequencer_if bus ();
  fetch_sequencer_if wbus ();

  logic              branch_en, jump_en, branch_taken;
  logic [ADDR_W-1:0] target_addr;
  logic              fetch_busy, wfetch_busy;

  fetch_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .branch_en   (branch_en),
    .jump_en     (jump_en),
    .branch_taken(branch_taken),
    .target_addr (target_addr),
    .fetch_busy  (fetch_busy)
  );

  fetch_sequencer #(.RESET_PC(16'hFFFE)) dut_w (
    .clk         (clk),
    .rst         (rst),
    .bus         (wbus),
    .branch_en   (1'b0),
    .jump_en     (1'b0),
    .branch_taken(1'b0),
    .target_addr (16'h0000),
    .fetch_busy  (wfetch_busy)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory contents: each word encodes its own address.
  function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[3:0] ^ 4'h9, 24'h5A5A5A, a, ~a};
  endfunction

  function automatic logic [OPCODE_W-1:0] exp_opcode(input logic [ADDR_W-1:0] a);
    return a[3:0] ^ 4'h9;
  endfunction

  localparam logic [INSTR_W-1:0] JUNK = 60'hEEEEEEEEEEEEEEE;

  // ---------------- behavioural memory for the main instance --------------
  bit                mem_ready = 1'b1;
  int                rsp_lat   = 1;
  bit                pending   = 1'b0;
  int                cnt       = 0;
  logic [ADDR_W-1:0] paddr;
  logic [ADDR_W-1:0] acc_q[$];
  logic [ADDR_W-1:0] xfer_q[$];

  initial begin
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = JUNK;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        pending            = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = JUNK;
        bus.imem_req_ready = mem_ready;
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = JUNK;
        if (pending) begin
          cnt--;
          if (cnt == 0) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_word(paddr);
            pending            = 1'b0;
          end
        end
        bus.imem_req_ready = mem_ready;
        if (bus.imem_req_valid && mem_ready) begin
          pending = 1'b1;
          cnt     = rsp_lat;
          paddr   = bus.imem_req_addr;
          acc_q.push_back(bus.imem_req_addr);
        end
        if (bus.instr_valid && bus.instr_ready) xfer_q.push_back(bus.instr_pc);
      end
    end
  end

  // ------------- always-ready 1-cycle memory for the wrap instance ---------
  bit                wpend = 1'b0;
  logic [ADDR_W-1:0] wpaddr;
  logic [ADDR_W-1:0] wacc_q[$];
  logic [ADDR_W-1:0] wxfer_q[$];

  initial begin
    wbus.imem_req_ready = 1'b1;
    wbus.instr_ready    = 1'b1;
    wbus.imem_rsp_valid = 1'b0;
    wbus.imem_rsp_data  = JUNK;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        wpend               = 1'b0;
        wbus.imem_rsp_valid = 1'b0;
        wbus.imem_rsp_data  = JUNK;
      end else begin
        wbus.imem_rsp_valid = wpend;
        wbus.imem_rsp_data  = wpend ? mem_word(wpaddr) : JUNK;
        wpend               = 1'b0;
        if (wbus.imem_req_valid) begin
          wpend  = 1'b1;
          wpaddr = wbus.imem_req_addr;
          wacc_q.push_back(wbus.imem_req_addr);
        end
        if (wbus.instr_valid) wxfer_q.push_back(wbus.instr_pc);
      end
    end
  end

  // ---------------------------- vector table -------------------------------
  typedef struct {
    bit                mr;    // memory accepts requests this cycle
    int                lat;   // response latency for a request accepted now
    bit                ir;    // decode ready
    bit                je;
    bit                be;
    bit                bt;
    logic [ADDR_W-1:0] tgt;
    bit                rv;    // expected imem_req_valid
    logic [ADDR_W-1:0] addr;  // expected imem_req_addr
    bit                iv;    // expected instr_valid
    logic [ADDR_W-1:0] ipc;   // expected instr_pc
    bit                busy;  // expected fetch_busy
  } vec_t;

  vec_t vq[$];

  task automatic row(input bit mr, input int lat, input bit ir, input bit je, input bit be,
                     input bit bt, input logic [ADDR_W-1:0] tgt, input bit rv,
                     input logic [ADDR_W-1:0] addr, input bit iv,
                     input logic [ADDR_W-1:0] ipc, input bit busy);
    vec_t v;
    v = '{mr, lat, ir, je, be, bt, tgt, rv, addr, iv, ipc, busy};
    vq.push_back(v);
  endtask

  task automatic build_table();
    // reset release, free-running fetch of 0..3 at 3-cycle spacing
    row(1,1,1,0,0,0,16'h0000, 0,16'h0000,0,16'h0000,0);
    row(1,1,1,0,0,0,16'h0000, 1,16'h0000,0,16'h0000,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0000,0,16'h0000,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0000,1,16'h0000,1);
    row(1,1,1,0,0,0,16'h0000, 1,16'h0001,0,16'h0000,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0001,0,16'h0000,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0001,1,16'h0001,1);
    row(1,1,1,0,0,0,16'h0000, 1,16'h0002,0,16'h0001,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0002,0,16'h0001,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0002,1,16'h0002,1);
    row(1,1,1,0,0,0,16'h0000, 1,16'h0003,0,16'h0002,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0003,0,16'h0002,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0003,1,16'h0003,1);
    // request backpressure: 5 cycles not ready, address must hold
    for (int k = 0; k < 5; k++) row(0,1,1,0,0,0,16'h0000, 1,16'h0004,0,16'h0003,1);
    row(1,1,1,0,0,0,16'h0000, 1,16'h0004,0,16'h0003,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0004,0,16'h0003,1);
    // decode backpressure: 4 cycles not ready, instruction must hold
    for (int k = 0; k < 4; k++) row(1,1,0,0,0,0,16'h0000, 0,16'h0004,1,16'h0004,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0004,1,16'h0004,1);
    row(1,1,1,0,0,0,16'h0000, 1,16'h0005,0,16'h0004,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0005,0,16'h0004,1);
    // jump in HOLD at PC 5, instruction withdrawn
    row(1,1,0,1,0,0,16'h0040, 0,16'h0005,1,16'h0005,1);
    row(1,1,1,0,0,0,16'h0000, 1,16'h0040,0,16'h0005,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0040,0,16'h0005,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0040,1,16'h0040,1);
    // taken branch in WAIT, stale response 2 cycles later
    row(1,3,1,0,0,0,16'h0000, 1,16'h0041,0,16'h0040,1);
    row(1,1,1,0,1,1,16'h0100, 0,16'h0041,0,16'h0040,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0100,0,16'h0040,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0100,0,16'h0040,1);
    row(1,1,1,0,0,0,16'h0000, 1,16'h0100,0,16'h0040,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0100,0,16'h0040,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0100,1,16'h0100,1);
    // not-taken branch in WAIT: no redirect
    row(1,3,1,0,0,0,16'h0000, 1,16'h0101,0,16'h0100,1);
    row(1,1,1,0,1,0,16'h0200, 0,16'h0101,0,16'h0100,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0101,0,16'h0100,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0101,0,16'h0100,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0101,1,16'h0101,1);
    // jump in WAIT coinciding with the response
    row(1,1,1,0,0,0,16'h0000, 1,16'h0102,0,16'h0101,1);
    row(1,1,1,1,0,0,16'h0300, 0,16'h0102,0,16'h0101,1);
    row(1,1,1,0,0,0,16'h0000, 1,16'h0300,0,16'h0101,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0300,0,16'h0101,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0300,1,16'h0300,1);
    // jump in REQ without ready, then jump in REQ with ready
    row(0,1,1,1,0,0,16'h0400, 1,16'h0301,0,16'h0300,1);
    row(1,1,1,1,0,0,16'h0500, 1,16'h0400,0,16'h0300,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0500,0,16'h0300,1);
    row(1,1,1,0,0,0,16'h0000, 1,16'h0500,0,16'h0300,1);
    row(1,1,1,0,0,0,16'h0000, 0,16'h0500,0,16'h0300,1);
    // jump in HOLD with decode ready: transfer completes, PC takes target
    row(1,1,1,1,0,0,16'h0600, 0,16'h0500,1,16'h0500,1);
    row(0,1,1,0,0,0,16'h0000, 1,16'h0600,0,16'h0500,1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_valid"},   64'(bus.imem_req_valid), 64'd0);
    check({tag, ".req_addr"},    64'(bus.imem_req_addr),  64'h0000);
    check({tag, ".instr_valid"}, 64'(bus.instr_valid),    64'd0);
    check({tag, ".instr_data"},  64'(bus.instr_data),     64'd0);
    check({tag, ".instr_pc"},    64'(bus.instr_pc),       64'd0);
    check({tag, ".opcode"},      64'(bus.opcode),         64'd0);
    check({tag, ".busy"},        64'(fetch_busy),         64'd0);
  endtask

  logic [ADDR_W-1:0] exp_acc[]  = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
                                    16'h0005, 16'h0040, 16'h0041, 16'h0100, 16'h0101,
                                    16'h0102, 16'h0300, 16'h0400, 16'h0500};
  logic [ADDR_W-1:0] exp_xfer[] = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0004,
                                    16'h0040, 16'h0100, 16'h0101, 16'h0300, 16'h0500};
  logic [ADDR_W-1:0] exp_wrap[] = '{16'hFFFE, 16'hFFFF, 16'h0000};

  initial begin
    bit got;
    rst              = 1'b1;
    branch_en        = 1'b0;
    jump_en          = 1'b0;
    branch_taken     = 1'b0;
    target_addr      = '0;
    bus.instr_ready  = 1'b1;
    build_table();

    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("reset");

    foreach (vq[i]) begin
      @(negedge clk);
      if (i == 0) rst = 1'b0;
      mem_ready       = vq[i].mr;
      rsp_lat         = vq[i].lat;
      bus.instr_ready = vq[i].ir;
      jump_en         = vq[i].je;
      branch_en       = vq[i].be;
      branch_taken    = vq[i].bt;
      target_addr     = vq[i].tgt;
      #2;
      check($sformatf("row%0d.req_valid", i),   64'(bus.imem_req_valid), 64'(vq[i].rv));
      check($sformatf("row%0d.req_addr", i),    64'(bus.imem_req_addr),  64'(vq[i].addr));
      check($sformatf("row%0d.instr_valid", i), 64'(bus.instr_valid),    64'(vq[i].iv));
      check($sformatf("row%0d.instr_pc", i),    64'(bus.instr_pc),       64'(vq[i].ipc));
      check($sformatf("row%0d.busy", i),        64'(fetch_busy),         64'(vq[i].busy));
      if (vq[i].iv) begin
        check($sformatf("row%0d.instr_data", i), 64'(bus.instr_data), 64'(mem_word(vq[i].ipc)));
        check($sformatf("row%0d.opcode", i),     64'(bus.opcode),     64'(exp_opcode(vq[i].ipc)));
      end
    end

    // Every accepted request and every completed transfer, in order.
    check("acc_count", 64'(acc_q.size()), 64'(exp_acc.size()));
    foreach (exp_acc[i])
      if (i < acc_q.size()) check($sformatf("acc%0d", i), 64'(acc_q[i]), 64'(exp_acc[i]));
    check("xfer_count", 64'(xfer_q.size()), 64'(exp_xfer.size()));
    foreach (exp_xfer[i])
      if (i < xfer_q.size()) check($sformatf("xfer%0d", i), 64'(xfer_q[i]), 64'(exp_xfer[i]));

    // Reset while a slow fetch is in WAIT.
    jump_en         = 1'b0;
    @(negedge clk);
    mem_ready       = 1'b1;
    rsp_lat         = 10;
    bus.instr_ready = 1'b1;
    #2;
    check("rstwait.pre_req", 64'(bus.imem_req_valid), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    #2;
    check("rstwait.in_wait_req", 64'(bus.imem_req_valid), 64'd0);
    check("rstwait.in_wait_busy", 64'(fetch_busy), 64'd1);
    @(negedge clk);
    rst     = 1'b0;
    rsp_lat = 1;
    #2;
    check_reset_outputs("rstwait");
    @(negedge clk);
    #2;
    check("rstwait.first_req_valid", 64'(bus.imem_req_valid), 64'd1);
    check("rstwait.first_req_addr",  64'(bus.imem_req_addr),  64'h0000);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      #2;
      if (bus.instr_valid) got = 1'b1;
    end
    check("rstwait.instr_arrived", 64'(got), 64'd1);
    check("rstwait.instr_pc",   64'(bus.instr_pc),   64'h0000);
    check("rstwait.instr_data", 64'(bus.instr_data), 64'(mem_word(16'h0000)));

    // PC wrap on the RESET_PC=FFFE instance (first run after power-on reset).
    check("wrap.acc_count",  64'(wacc_q.size() >= 3),  64'd1);
    check("wrap.xfer_count", 64'(wxfer_q.size() >= 3), 64'd1);
    foreach (exp_wrap[i]) begin
      if (i < wacc_q.size())  check($sformatf("wrap.acc%0d", i),  64'(wacc_q[i]),  64'(exp_wrap[i]));
      if (i < wxfer_q.size()) check($sformatf("wrap.xfer%0d", i), 64'(wxfer_q[i]), 64'(exp_wrap[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch sequencer for the 60-bit processor: owns the program counter, issues one instruction-memory read at a time over a valid/ready request channel, and presents the fetched word and its 4-bit opcode to the control unit. It consumes the control unit's `branch_en`/`jump_en` outputs, together with the ALU branch condition and target, to redirect the PC and discard stale fetches. It sits between instruction memory and decode.

## Interface
- `INSTR_W`, 60, instruction word width
- `ADDR_W`, 16, instruction address width (word addressed)
- `OPCODE_W`, 4, opcode field width; the field is `instr_data[INSTR_W-1 -: OPCODE_W]`
- `RESET_PC`, 0, PC value after reset

Ports:
- `clk` in 1: the single clock; all state updates on rising edge
- `rst` in 1: reset, synchronous, active-high
- `imem_req_valid` out 1: fetch request valid
- `imem_req_ready` in 1: memory accepts request
- `imem_req_addr` out ADDR_W: fetch address (= PC)
- `imem_rsp_valid` in 1: read data valid, one pulse per accepted request
- `imem_rsp_data` in INSTR_W: read data
- `instr_valid` out 1: fetched instruction available to decode
- `instr_ready` in 1: decode accepts instruction
- `instr_data` out INSTR_W: fetched instruction
- `instr_pc` out ADDR_W: address of `instr_data`
- `opcode` out OPCODE_W: opcode field of `instr_data`, feeds control unit
- `branch_en` in 1: from control unit
- `jump_en` in 1: from control unit
- `branch_taken` in 1: ALU branch condition
- `target_addr` in ADDR_W: redirect target
- `fetch_busy` out 1: high when state is not IDLE

## Operation
- `redirect = jump_en | (branch_en & branch_taken)`. It is a single-cycle pulse, and a redirect takes priority over every other PC update.
- FSM states:
  - IDLE: no outputs asserted; moves to REQ on the next edge.
  - REQ: `imem_req_valid=1` and `imem_req_addr=pc`. When `imem_req_ready` is high, move to WAIT.
  - WAIT: wait for `imem_rsp_valid`. When it arrives, capture `instr_data` and `instr_pc=pc`, then move to HOLD. If the `discard` flag is set, drop the data, clear `discard`, and move to REQ.
  - HOLD: `instr_valid=1`. When `instr_ready` is high, set `pc<=pc+1` and move to REQ.
- Redirect handling by state:
  - REQ without `imem_req_ready`: `pc<=target_addr`, stay in REQ. The request address changes the next cycle; this is allowed because the request was not accepted.
  - REQ with `imem_req_ready` in the same cycle: the request is accepted, `pc<=target_addr`, `discard<=1`, move to WAIT.
  - WAIT: `pc<=target_addr` and `discard<=1`. If `imem_rsp_valid` arrives in the same cycle, drop that response and move directly to REQ with `discard` left at 0.
  - HOLD: `pc<=target_addr`, move to REQ, and the held instruction is withdrawn. If `instr_ready` is high in the same cycle, the transfer still completes, but the PC takes the target rather than pc+1.
- PC arithmetic is modulo 2^ADDR_W: `pc=16'hFFFF` increments to 0. `target_addr` is used unmodified.
- At most one request is outstanding at any time.
- Reset values:
  - state IDLE, `pc=RESET_PC`, `discard=0`
  - `imem_req_valid=0`, `instr_valid=0`, `fetch_busy=0`
  - `instr_data=0`, `instr_pc=0`, `opcode=0`
  - `imem_req_addr=RESET_PC`
- Reset mid-operation: any in-flight request is abandoned. Instruction memory shares `rst`, so no response may arrive after reset; the bench enforces this.

## Timing
- `imem_req_valid` and `instr_valid` decode directly from the state register, so neither output has a combinational path from any input.
- `imem_req_addr` is the PC register.
- First request: `rst` is low at edge E0 (IDLE to REQ), and `imem_req_valid` is high in the cycle after E0.
- Best-case throughput with an always-ready decode and a one-cycle memory is 3 cycles per instruction:
  - REQ accepted at edge N
  - response at edge N+1, so `instr_valid` is high after N+1
  - `instr_ready` at edge N+2, with the next REQ after N+2
- `imem_req_addr` is stable while REQ is held without `imem_req_ready`, unless a redirect occurs.
- `instr_data`, `instr_pc` and `opcode` are stable while `instr_valid=1` and `instr_ready=0`.
- Redirect-to-new-request latency: 1 cycle from REQ or HOLD. From WAIT it is 1 cycle after the stale response arrives.

## Structure
- Package `fetch_pkg` holds:
  - the state enum (IDLE, REQ, WAIT, HOLD)
  - the `INSTR_W`, `ADDR_W` and `OPCODE_W` defaults
  - the opcode field position
  - an opcode-extract function
- The control unit imports the same opcode constants.
- No sub-module: this is a single FSM plus the PC and instruction registers.

## Test plan
- Reset then free-running: memory always ready with a 1-cycle response, decode always ready. Required: requests to addresses 0, 1, 2, 3 at 3-cycle spacing, `instr_pc` matches each address, and `opcode` equals the top 4 bits of each word.
- Backpressure: hold `imem_req_ready=0` for 5 cycles and then `instr_ready=0` for 4 cycles. Required: address and data remain stable throughout, and no duplicate or skipped PC.
- Jump in HOLD: `jump_en=1` with `target_addr=16'h0040` at PC 5. Required: the next request address is `0040`, and the instruction at PC 6 is never requested.
- Branch in WAIT: `branch_en=1`, `branch_taken=1`, target `0x0100`, with the response arriving 2 cycles later. Required: the stale response produces no `instr_valid`, and the next request goes to `0100`. Repeat with `branch_taken=0`: no redirect occurs.
- PC wrap: `RESET_PC=16'hFFFE`. Required: fetch sequence FFFE, FFFF, 0000.
- Reset asserted while in WAIT. Required: outputs take their reset values the next cycle, and the first request after release goes to `RESET_PC`.
